ifu_pc_gen: RTL
===============

// Module: ifu_pc_gen
// PURPOSE
//  Fetch-side PC generator. Drives instruction fetch requests (pc_req) to memory and tracks outstanding fetches.
//  Returns each fetched PC plus instruction to the branch predictor on the pc_rsp valid/ready channel.
//  Takes two redirects: a BPU predicted-taken target (op1+op2) and an EXU flush.
//  Discards stale in-flight responses after either redirect.
// PARAMETERS
//  AW         32            address width
//  RESET_PC   32'h8000_0000 first fetch address after reset
//  OST_DEPTH  2             max outstanding fetches (power of 2, >=1)
// PORTS
//  clk              in  1   clock
//  rst              in  1   reset, synchronous, active-high
//  pc_req_vld_o     out 1   fetch request valid
//  pc_req_rdy_i     in  1   memory accepts request
//  pc_req_addr_o    out AW  fetch address
//  mem_rsp_vld_i    in  1   memory instruction valid
//  mem_rsp_rdy_o    out 1   block accepts memory response
//  mem_rsp_ins_i    in  32  fetched instruction
//  pc_rsp_vld_o     out 1   response valid to BPU
//  pc_rsp_rdy_i     in  1   BPU accepts response
//  pc_rsp_pc_o      out AW  PC of returned instruction
//  pc_rsp_ins_o     out 32  returned instruction (= mem_rsp_ins_i)
//  bpu_taken_i      in  1   BPU registered taken flag; level, held until our next pc_req handshake
//  bpu_jump_op1_i   in  AW  BPU target operand 1
//  bpu_jump_op2_i   in  AW  BPU target operand 2
//  flush_vld_i      in  1   EXU flush, single-cycle pulse
//  flush_pc_i       in  AW  flush target
// BEHAVIOUR
//  State
//  - pc_r: next sequential fetch PC.
//  - ost FIFO: OST_DEPTH entries of issued PCs, plus count ost_cnt.
//  - kill_cnt: width clog2(OST_DEPTH+1).
//  - ign_bpu: 1-bit flag.
//  Reset
//  - pc_r=RESET_PC; ost empty; kill_cnt=0; ign_bpu=0.
//  - pc_req_vld_o=0 and pc_rsp_vld_o=0 during reset.
//  - Responses to pre-reset requests are not supported; memory is reset together with this block.
//  Request side
//  - pc_req_vld_o = ~flush_vld_i & (ost_cnt<OST_DEPTH). It never depends on pc_req_rdy_i.
//  - tgt = bpu_jump_op1_i + bpu_jump_op2_i, modulo 2^AW. Low bits are passed unmodified.
//  - use_bpu = bpu_taken_i & ~ign_bpu.
//  - pc_req_addr_o = use_bpu ? tgt : pc_r.
//  - On request handshake: push pc_req_addr_o into ost, then pc_r <= pc_req_addr_o+4 (wraps).
//  - On request handshake with use_bpu: kill_cnt <= ost_cnt minus any pop this cycle, counted before this push.
//  - Zero-latency request path: an address accepted in cycle N is in ost at N+1.
//  Response side
//  - kill = (kill_cnt!=0).
//  - pc_rsp_vld_o = mem_rsp_vld_i & ~kill & ~flush_vld_i.
//  - mem_rsp_rdy_o = kill | flush_vld_i | pc_rsp_rdy_i.
//  - pc_rsp_pc_o = ost head. The response path is combinational, 0 cycles.
//  - Every mem handshake pops ost. If kill, the response is dropped and kill_cnt decrements.
//  - Memory returns responses in order and never returns a response with ost empty.
//  Flush
//  - Highest priority over everything.
//  - In the flush cycle: no request issued; pc_r <= flush_pc_i.
//  - kill_cnt <= ost_cnt minus this cycle's pop.
//  - ign_bpu <= bpu_taken_i. ign_bpu clears on the next request handshake, so a stale BPU target is never used.
//  Simultaneous events
//  - Push and pop in the same cycle: ost_cnt is unchanged.
//  - Flush and BPU taken in the same cycle: flush wins.
//  - Redirect with ost empty: kill_cnt=0.
// TESTING
//  1. Release reset; hold pc_req_rdy_i=1; memory replies 1 cycle later.
//     -> requests 0x80000000, 0x80000004, 0x80000008.
//     -> pc_rsp_pc_o matches in order.
//  2. Hold pc_rsp_rdy_i=0 with 2 outstanding.
//     -> pc_req_vld_o=0 and mem_rsp_rdy_o=0.
//     -> release: responses delivered in order, none lost.
//  3. bpu_taken_i=1, op1=0x80000010, op2=0xFFFFFFF8, 1 fetch in flight.
//     -> pc_req_addr_o=0x80000008, next request 0x8000000C.
//     -> the in-flight response is dropped, pc_rsp_vld_o stays 0.
//  4. flush_vld_i with flush_pc_i=0x80001000, 2 outstanding.
//     -> pc_req_vld_o=0 in the flush cycle; both stale responses dropped.
//     -> next request 0x80001000.
//  5. flush_vld_i and bpu_taken_i in the same cycle, tgt=0x80000040.
//     -> next request 0x80001000; 0x80000040 is never issued.
//  6. RESET_PC=32'hFFFFFFFC.
//     -> second request address 0x00000000 (wrap).

Source files
------------

// File: rtl/ifu_pc_gen.sv
// Fetch-side PC generator.
// Issues sequential or redirected fetch addresses and records every issued PC
// in a small in-order FIFO. Memory responses are paired with the FIFO head and
// forwarded to the branch predictor. Responses that belong to fetches issued
// before a redirect (BPU taken or EXU flush) are counted in kill_cnt_reg and
// silently drained.
module ifu_pc_gen #(
    parameter int            AW        = 32,
    parameter logic [AW-1:0] RESET_PC  = AW'(32'h8000_0000),
    parameter int            OST_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    // fetch request to memory
    output logic          pc_req_vld_o,
    input  logic          pc_req_rdy_i,
    output logic [AW-1:0] pc_req_addr_o,
    // instruction return from memory
    input  logic          mem_rsp_vld_i,
    output logic          mem_rsp_rdy_o,
    input  logic [31:0]   mem_rsp_ins_i,
    // PC + instruction towards the BPU
    output logic          pc_rsp_vld_o,
    input  logic          pc_rsp_rdy_i,
    output logic [AW-1:0] pc_rsp_pc_o,
    output logic [31:0]   pc_rsp_ins_o,
    // BPU predicted-taken redirect
    input  logic          bpu_taken_i,
    input  logic [AW-1:0] bpu_jump_op1_i,
    input  logic [AW-1:0] bpu_jump_op2_i,
    // EXU flush redirect
    input  logic          flush_vld_i,
    input  logic [AW-1:0] flush_pc_i
);

    localparam int CW = $clog2(OST_DEPTH + 1);
    localparam int PW = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0] pc_reg;
    logic [AW-1:0] ost_mem [OST_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] ost_cnt_reg;
    logic [CW-1:0] kill_cnt_reg;
    logic          ign_bpu_reg;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic          ost_full;
    logic          use_bpu;
    logic [AW-1:0] bpu_tgt;
    logic          req_hs;
    logic          kill;
    logic          mem_hs;
    logic [CW-1:0] ost_cnt_after_pop;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_next;
    logic [OST_DEPTH-1:0] ost_wr_en;

    assign ost_full      = (ost_cnt_reg == CW'(OST_DEPTH));
    assign bpu_tgt       = bpu_jump_op1_i + bpu_jump_op2_i;
    // A flush captured a taken flag that still refers to the old path;
    // that target must not be used on the first post-flush request.
    assign use_bpu       = bpu_taken_i & ~ign_bpu_reg;

    assign pc_req_vld_o  = ~rst & ~flush_vld_i & ~ost_full;
    assign pc_req_addr_o = use_bpu ? bpu_tgt : pc_reg;
    assign req_hs        = pc_req_vld_o & pc_req_rdy_i;

    assign kill          = (kill_cnt_reg != '0);
    assign pc_rsp_vld_o  = ~rst & mem_rsp_vld_i & ~kill & ~flush_vld_i;
    assign mem_rsp_rdy_o = kill | flush_vld_i | pc_rsp_rdy_i;
    assign mem_hs        = mem_rsp_vld_i & mem_rsp_rdy_o;
    assign pc_rsp_pc_o   = ost_mem[rd_ptr_reg];
    assign pc_rsp_ins_o  = mem_rsp_ins_i;

    // Entries still outstanding after this cycle's pop, before this cycle's push:
    // exactly the fetches that become stale on a redirect.
    assign ost_cnt_after_pop = ost_cnt_reg - CW'(mem_hs);

    assign wr_ptr_next = (wr_ptr_reg == PW'(OST_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
    assign rd_ptr_next = (rd_ptr_reg == PW'(OST_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < OST_DEPTH; gi++) begin : g_ost_wr_en
            assign ost_wr_en[gi] = req_hs & (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // Outstanding-PC storage: the accepted request address lands in the slot at wr_ptr.
    always_ff @(posedge clk) begin
        for (int i = 0; i < OST_DEPTH; i++) begin
            if (ost_wr_en[i]) begin
                ost_mem[i] <= pc_req_addr_o;
            end
        end
    end

    // FIFO pointers and occupancy; push on request handshake, pop on every memory handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            ost_cnt_reg <= '0;
        end else begin
            if (req_hs) begin
                wr_ptr_reg <= wr_ptr_next;
            end
            if (mem_hs) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            case ({req_hs, mem_hs})
                2'b10:   ost_cnt_reg <= ost_cnt_reg + 1'b1;
                2'b01:   ost_cnt_reg <= ost_cnt_reg - 1'b1;
                default: ost_cnt_reg <= ost_cnt_reg;
            endcase
        end
    end

    // Next sequential PC: flush target wins, otherwise follow the issued address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC;
        end else if (flush_vld_i) begin
            pc_reg <= flush_pc_i;
        end else if (req_hs) begin
            pc_reg <= pc_req_addr_o + AW'(4);
        end
    end

    // Stale-response counter: loaded on any redirect, drained by dropped responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            kill_cnt_reg <= '0;
        end else if (flush_vld_i) begin
            kill_cnt_reg <= ost_cnt_after_pop;
        end else if (req_hs && use_bpu) begin
            kill_cnt_reg <= ost_cnt_after_pop;
        end else if (mem_hs && kill) begin
            kill_cnt_reg <= kill_cnt_reg - 1'b1;
        end
    end

    // Ignore a taken flag that was already up when a flush arrived, until the next request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ign_bpu_reg <= 1'b0;
        end else if (flush_vld_i) begin
            ign_bpu_reg <= bpu_taken_i;
        end else if (req_hs) begin
            ign_bpu_reg <= 1'b0;
        end
    end

endmodule
